// File: rtl/multi_channel_wave_generator_pkg.sv
// Shared encodings for the multi-channel DDS wave generator: waveform modes
// and frame sequencer states.
package multi_channel_wave_generator_pkg;

    typedef enum logic [1:0] {
        MODE_SINE   = 2'b00,
        MODE_SAW    = 2'b01,
        MODE_TRI    = 2'b10,
        MODE_SQUARE = 2'b11
    } wave_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } gen_state_e;

endpackage

// File: rtl/multi_channel_wave_generator_sine_lut.sv
// Combinational quarter-wave sine magnitude table. Entries are
// round(127*sin(pi/2*(i+0.5)/64)), i.e. sized for LUT_AW=6 and N_FRAC=7.
module sine_quarter_lut
    import multi_channel_wave_generator_pkg::*;
#(
    parameter int LUT_AW = 6,
    parameter int N_FRAC = 7
) (
    input  logic [LUT_AW-1:0] addr,
    output logic [N_FRAC-1:0] mag
);

    localparam logic [7:0] TABLE [0:63] = '{
        8'd2,   8'd5,   8'd8,   8'd11,  8'd14,  8'd17,  8'd20,  8'd23,
        8'd26,  8'd29,  8'd32,  8'd35,  8'd38,  8'd41,  8'd44,  8'd47,
        8'd50,  8'd53,  8'd56,  8'd58,  8'd61,  8'd64,  8'd67,  8'd69,
        8'd72,  8'd74,  8'd77,  8'd79,  8'd82,  8'd84,  8'd86,  8'd89,
        8'd91,  8'd93,  8'd95,  8'd97,  8'd99,  8'd101, 8'd103, 8'd105,
        8'd106, 8'd108, 8'd110, 8'd111, 8'd113, 8'd114, 8'd115, 8'd117,
        8'd118, 8'd119, 8'd120, 8'd121, 8'd122, 8'd123, 8'd124, 8'd124,
        8'd125, 8'd125, 8'd126, 8'd126, 8'd127, 8'd127, 8'd127, 8'd127
    };

    // Table lookup, truncated to the magnitude width.
    always_comb begin
        mag = TABLE[addr][N_FRAC-1:0];
    end

endmodule

// File: rtl/multi_channel_wave_generator.sv
// N_CH-channel DDS: per-channel phase accumulators, selectable waveform and
// signed amplitude scaling, streamed channel by channel through a 2-stage pipe.
module multi_channel_wave_generator
    import multi_channel_wave_generator_pkg::*;
#(
    parameter int N_FRAC  = 7,
    parameter int N_CH    = 2,
    parameter int PHASE_W = 12,
    parameter int LUT_AW  = 6,
    localparam int W      = N_FRAC + 1,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                next_data_strobe_i,
    input  logic                phase_clr_i,
    input  logic                cfg_we_i,
    input  logic [CH_W-1:0]     cfg_ch_i,
    input  logic [PHASE_W-1:0]  cfg_phase_inc_i,
    input  logic [W-1:0]        cfg_amplitude_i,
    input  logic [1:0]          cfg_mode_i,
    output logic [W-1:0]        data_o,
    output logic [CH_W-1:0]     data_ch_o,
    output logic                data_out_valid_strobe_o,
    output logic                busy_o,
    output logic                overrun_o
);

    localparam logic [W-1:0] POS_MAX  = {1'b0, {N_FRAC{1'b1}}};
    localparam logic [W-1:0] NEG_MIN  = {1'b1, {N_FRAC{1'b0}}};
    localparam logic [W-1:0] NEG_MAX  = {1'b1, {(N_FRAC-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] HALF     = {1'b1, {N_FRAC{1'b0}}};
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    function automatic logic [W-1:0] sat_q(input logic [2*W-1:0] v);
        if ((&v[2*W-1:W-1]) || (~|v[2*W-1:W-1])) begin
            sat_q = v[W-1:0];
        end else if (v[2*W-1]) begin
            sat_q = NEG_MIN;
        end else begin
            sat_q = POS_MAX;
        end
    endfunction

    logic [PHASE_W-1:0] acc_r      [N_CH];
    logic [PHASE_W-1:0] shd_inc_r  [N_CH];
    logic [W-1:0]       shd_amp_r  [N_CH];
    wave_mode_e         shd_mode_r [N_CH];
    logic [W-1:0]       act_amp_r  [N_CH];
    wave_mode_e         act_mode_r [N_CH];

    gen_state_e         state_r, next_state_s;
    logic [CH_W-1:0]    issue_ch_r;
    logic               issue_s, strobe_ok_s;
    logic               busy_r, overrun_r;

    logic               msb_s;
    logic [W-1:0]       u_s;
    logic [LUT_AW-1:0]  lut_addr_s;
    logic [N_FRAC-1:0]  lut_mag_s;
    logic [W-1:0]       lut_ext_s;
    logic [W-1:0]       wave_s;

    logic               s1_vld_r;
    logic [CH_W-1:0]    s1_ch_r;
    logic [W-1:0]       s1_wave_r;
    logic [W-1:0]       amp_s;
    logic signed [2*W-1:0] prod_s;
    logic signed [2*W-1:0] shr_s;

    logic [W-1:0]       data_r;
    logic [CH_W-1:0]    data_ch_r;
    logic               valid_r;

    assign strobe_ok_s = next_data_strobe_i && (state_r == ST_IDLE);

    // Frame sequencer: next state and channel-issue enable.
    always_comb begin
        next_state_s = state_r;
        issue_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (strobe_ok_s) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                issue_s = 1'b1;
                if (issue_ch_r == LAST_CH) begin
                    next_state_s = ST_DRAIN;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!s1_vld_r) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Sequencer state, issue counter, busy and overrun flags.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r    <= ST_IDLE;
            issue_ch_r <= {CH_W{1'b0}};
            busy_r     <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            issue_ch_r <= (issue_s && (issue_ch_r != LAST_CH)) ? issue_ch_r + CH_W'(1'b1)
                                                              : {CH_W{1'b0}};
            busy_r     <= (next_state_s != ST_IDLE);
            overrun_r  <= next_data_strobe_i && (state_r != ST_IDLE);
        end
    end

    // Shadow/active config and phase accumulators; a clear wins over the advance.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int c = 0; c < N_CH; c++) begin
                acc_r[c]      <= {PHASE_W{1'b0}};
                shd_inc_r[c]  <= {PHASE_W{1'b0}};
                shd_amp_r[c]  <= {W{1'b0}};
                shd_mode_r[c] <= MODE_SINE;
                act_amp_r[c]  <= {W{1'b0}};
                act_mode_r[c] <= MODE_SINE;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (phase_clr_i) begin
                    acc_r[c] <= {PHASE_W{1'b0}};
                end else if (strobe_ok_s) begin
                    acc_r[c] <= acc_r[c] + shd_inc_r[c];
                end else begin
                    acc_r[c] <= acc_r[c];
                end
                if (strobe_ok_s) begin
                    act_amp_r[c]  <= shd_amp_r[c];
                    act_mode_r[c] <= shd_mode_r[c];
                end else begin
                    act_amp_r[c]  <= act_amp_r[c];
                    act_mode_r[c] <= act_mode_r[c];
                end
                if (cfg_we_i && (cfg_ch_i == CH_W'(c))) begin
                    shd_inc_r[c]  <= cfg_phase_inc_i;
                    shd_amp_r[c]  <= cfg_amplitude_i;
                    shd_mode_r[c] <= wave_mode_e'(cfg_mode_i);
                end else begin
                    shd_inc_r[c]  <= shd_inc_r[c];
                    shd_amp_r[c]  <= shd_amp_r[c];
                    shd_mode_r[c] <= shd_mode_r[c];
                end
            end
        end
    end

    // Phase fields of the channel being issued; odd quadrants mirror the table.
    always_comb begin
        msb_s      = acc_r[issue_ch_r][PHASE_W-1];
        u_s        = acc_r[issue_ch_r][PHASE_W-2 -: W];
        lut_addr_s = acc_r[issue_ch_r][PHASE_W-2] ? ~acc_r[issue_ch_r][PHASE_W-3 -: LUT_AW]
                                                  :  acc_r[issue_ch_r][PHASE_W-3 -: LUT_AW];
    end

    sine_quarter_lut #(
        .LUT_AW (LUT_AW),
        .N_FRAC (N_FRAC)
    ) u_sine_lut (
        .addr (lut_addr_s),
        .mag  (lut_mag_s)
    );

    // Waveform select for the issued channel.
    always_comb begin
        lut_ext_s = {1'b0, lut_mag_s};
        wave_s    = lut_ext_s;
        case (act_mode_r[issue_ch_r])
            MODE_SINE:   wave_s = msb_s ? ({W{1'b0}} - lut_ext_s) : lut_ext_s;
            MODE_SAW:    wave_s = {~msb_s, u_s[W-1:1]};
            MODE_TRI:    wave_s = msb_s ? (POS_MAX - u_s) : (u_s - HALF);
            MODE_SQUARE: wave_s = msb_s ? NEG_MAX : POS_MAX;
            default:     wave_s = lut_ext_s;
        endcase
    end

    // Stage 1: register the raw waveform sample.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s1_vld_r  <= 1'b0;
            s1_ch_r   <= {CH_W{1'b0}};
            s1_wave_r <= {W{1'b0}};
        end else begin
            s1_vld_r <= issue_s;
            if (issue_s) begin
                s1_ch_r   <= issue_ch_r;
                s1_wave_r <= wave_s;
            end else begin
                s1_ch_r   <= s1_ch_r;
                s1_wave_r <= s1_wave_r;
            end
        end
    end

    // Signed Q1.N_FRAC multiply; arithmetic shift floors toward -inf.
    always_comb begin
        amp_s  = act_amp_r[s1_ch_r];
        prod_s = $signed({{W{s1_wave_r[W-1]}}, s1_wave_r}) * $signed({{W{amp_s[W-1]}}, amp_s});
        shr_s  = prod_s >>> N_FRAC;
    end

    // Stage 2: saturated output sample; data holds between pulses.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_r   <= 1'b0;
            data_r    <= {W{1'b0}};
            data_ch_r <= {CH_W{1'b0}};
        end else begin
            valid_r <= s1_vld_r;
            if (s1_vld_r) begin
                data_r    <= sat_q(shr_s);
                data_ch_r <= s1_ch_r;
            end else begin
                data_r    <= data_r;
                data_ch_r <= data_ch_r;
            end
        end
    end

    assign data_o                  = data_r;
    assign data_ch_o               = data_ch_r;
    assign data_out_valid_strobe_o = valid_r;
    assign busy_o                  = busy_r;
    assign overrun_o               = overrun_r;

endmodule

// File: tb/tb_multi_channel_wave_generator.sv
// Directed self-checking bench for multi_channel_wave_generator (2 channels, Q1.7).
module tb_multi_channel_wave_generator;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              next_data_strobe_i;
    logic              phase_clr_i;
    logic              cfg_we_i;
    logic [0:0]        cfg_ch_i;
    logic [11:0]       cfg_phase_inc_i;
    logic signed [7:0] cfg_amplitude_i;
    logic [1:0]        cfg_mode_i;
    logic signed [7:0] data_o;
    logic [0:0]        data_ch_o;
    logic              data_out_valid_strobe_o;
    logic              busy_o;
    logic              overrun_o;

    int n_vec = 0;
    int n_err = 0;

    multi_channel_wave_generator #(
        .N_FRAC  (7),
        .N_CH    (2),
        .PHASE_W (12),
        .LUT_AW  (6)
    ) dut (
        .clk_i                   (clk_i),
        .rst_i                   (rst_i),
        .next_data_strobe_i      (next_data_strobe_i),
        .phase_clr_i             (phase_clr_i),
        .cfg_we_i                (cfg_we_i),
        .cfg_ch_i                (cfg_ch_i),
        .cfg_phase_inc_i         (cfg_phase_inc_i),
        .cfg_amplitude_i         (cfg_amplitude_i),
        .cfg_mode_i              (cfg_mode_i),
        .data_o                  (data_o),
        .data_ch_o               (data_ch_o),
        .data_out_valid_strobe_o (data_out_valid_strobe_o),
        .busy_o                  (busy_o),
        .overrun_o               (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cfg_write(input logic ch, input logic [11:0] inc,
                             input logic signed [7:0] amp, input logic [1:0] mode);
        cfg_we_i        = 1'b1;
        cfg_ch_i        = ch;
        cfg_phase_inc_i = inc;
        cfg_amplitude_i = amp;
        cfg_mode_i      = mode;
        tick();
        cfg_we_i        = 1'b0;
    endtask

    // One frame: strobe in cycle 0, optional clear with it, optional ch0 write in cycle 1.
    task automatic frame(input string tag, input bit clr, input bit mid_wr,
                         input logic [11:0] mid_inc, input int exp0, input int exp1);
        next_data_strobe_i = 1'b1;
        phase_clr_i        = clr;
        tick();
        next_data_strobe_i = 1'b0;
        phase_clr_i        = 1'b0;
        check_eq({tag, "_busy_c1"}, busy_o, 1);
        check_eq({tag, "_vld_c1"}, data_out_valid_strobe_o, 0);
        if (mid_wr) begin
            cfg_we_i        = 1'b1;
            cfg_ch_i        = 1'b0;
            cfg_phase_inc_i = mid_inc;
            cfg_amplitude_i = 8'sd127;
            cfg_mode_i      = 2'b00;
        end
        tick();
        cfg_we_i = 1'b0;
        check_eq({tag, "_busy_c2"}, busy_o, 1);
        tick();
        check_eq({tag, "_vld_c3"}, data_out_valid_strobe_o, 1);
        check_eq({tag, "_ch_c3"}, data_ch_o, 0);
        check_eq({tag, "_d0"}, data_o, exp0);
        tick();
        check_eq({tag, "_vld_c4"}, data_out_valid_strobe_o, 1);
        check_eq({tag, "_ch_c4"}, data_ch_o, 1);
        check_eq({tag, "_d1"}, data_o, exp1);
        check_eq({tag, "_busy_c4"}, busy_o, 1);
        tick();
        check_eq({tag, "_busy_c5"}, busy_o, 0);
        check_eq({tag, "_vld_c5"}, data_out_valid_strobe_o, 0);
        check_eq({tag, "_hold_c5"}, data_o, exp1);
    endtask

    initial begin
        int pulses;
        int ovr;
        int d0_seen;

        rst_i              = 1'b0;
        next_data_strobe_i = 1'b0;
        phase_clr_i        = 1'b0;
        cfg_we_i           = 1'b0;
        cfg_ch_i           = 1'b0;
        cfg_phase_inc_i    = 12'd0;
        cfg_amplitude_i    = 8'sd0;
        cfg_mode_i         = 2'b00;
        #12;
        check_eq("rst_data", data_o, 0);
        check_eq("rst_vld", data_out_valid_strobe_o, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_ovr", overrun_o, 0);
        tick();
        rst_i = 1'b1;
        tick();

        // 1: square full scale on ch0, ch1 silent
        cfg_write(1'b0, 12'd0, 8'sd127, 2'b11);
        frame("sq", 1'b0, 1'b0, 12'd0, 126, 0);

        // 2: sine quarter steps around one turn, wrapping at 4096
        cfg_write(1'b0, 12'd1024, 8'sd127, 2'b00);
        frame("sin1024", 1'b0, 1'b0, 12'd0, 126, 0);
        frame("sin2048", 1'b0, 1'b0, 12'd0, -2, 0);
        frame("sin3072", 1'b0, 1'b0, 12'd0, -127, 0);
        frame("sin0", 1'b0, 1'b0, 12'd0, 1, 0);

        // 3: saw at -128 times amp -128 saturates
        cfg_write(1'b1, 12'd0, -8'sd128, 2'b01);
        frame("saw_sat", 1'b0, 1'b0, 12'd0, 126, 127);

        // 4: second strobe while busy is dropped and flagged
        pulses  = 0;
        ovr     = 0;
        d0_seen = 999;
        next_data_strobe_i = 1'b1;
        tick();
        next_data_strobe_i = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (data_out_valid_strobe_o) begin
                pulses++;
                if (data_ch_o == 1'b0) d0_seen = data_o;
            end
            if (overrun_o) ovr++;
            if (cyc == 3) check_eq("ovr_c3", overrun_o, 1);
            next_data_strobe_i = (cyc == 2);
            tick();
        end
        next_data_strobe_i = 1'b0;
        check_eq("ovr_pulses", pulses, 2);
        check_eq("ovr_count", ovr, 1);
        check_eq("ovr_d0", d0_seen, -2);
        frame("after_ovr", 1'b0, 1'b0, 12'd0, -127, 127);

        // 5: write during busy takes effect next frame; phase clear
        frame("midwr", 1'b0, 1'b1, 12'd512, 1, 127);
        frame("inc512", 1'b0, 1'b0, 12'd0, 90, 127);
        phase_clr_i = 1'b1;
        tick();
        phase_clr_i = 1'b0;
        frame("clr_idle", 1'b0, 1'b0, 12'd0, 90, 127);
        frame("clr_strobe", 1'b1, 1'b0, 12'd0, 1, 127);

        // 6: asynchronous reset in the middle of a frame
        next_data_strobe_i = 1'b1;
        tick();
        next_data_strobe_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        check_eq("arst_data", data_o, 0);
        check_eq("arst_vld", data_out_valid_strobe_o, 0);
        check_eq("arst_busy", busy_o, 0);
        tick();
        tick();
        rst_i  = 1'b1;
        pulses = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            tick();
            if (data_out_valid_strobe_o) pulses++;
        end
        check_eq("arst_no_vld", pulses, 0);
        cfg_write(1'b0, 12'd1024, 8'sd127, 2'b00);
        frame("arst_restart", 1'b0, 1'b0, 12'd0, 126, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
